// File: rtl/vram_dp_clr.sv
// vram_dp_clr: true dual-port framebuffer RAM with byte enables, a 1/2-cycle read pipeline,
// port-A-wins write arbitration and an optional clear/fill engine on port B (macro VRAM_CLR_EN).
module vram_dp_clr #(
   parameter  int DATA_W     = 16,
   parameter  int ADDR_W     = 18,
   parameter  int DEPTH      = 153600,
   parameter  int RD_LATENCY = 1,
   localparam int BE_W       = DATA_W / 8
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_a_enable,
   input  logic [ADDR_W-1:0] i_a_address,
   input  logic              i_a_write_enable,
   input  logic [BE_W-1:0]   i_a_byte_enable,
   input  logic [DATA_W-1:0] i_a_wr_data,
   output logic [DATA_W-1:0] o_a_rd_data,
   output logic              o_a_rd_valid,
   input  logic              i_b_enable,
   input  logic [ADDR_W-1:0] i_b_address,
   input  logic              i_b_write_enable,
   input  logic [BE_W-1:0]   i_b_byte_enable,
   input  logic [DATA_W-1:0] i_b_wr_data,
   output logic [DATA_W-1:0] o_b_rd_data,
   output logic              o_b_rd_valid,
   output logic              o_b_ready,
   output logic              o_collision,
   input  logic              i_clr_start,
   input  logic [ADDR_W-1:0] i_clr_base,
   input  logic [ADDR_W-1:0] i_clr_count,
   input  logic [DATA_W-1:0] i_clr_value,
   output logic              o_clr_busy,
   output logic              o_clr_done
);

   localparam int              LP_IDX_W = $clog2(DEPTH);
   localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);

   logic [DATA_W-1:0] r_mem [DEPTH];

   logic              w_fill_wr;
   logic [ADDR_W-1:0] w_fill_addr;
   logic [DATA_W-1:0] w_fill_data;
   logic              w_b_ready;

`ifdef VRAM_CLR_EN
   localparam logic [ADDR_W-1:0] LP_LAST = ADDR_W'(DEPTH - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} fill_state_t;

   fill_state_t       r_state;
   logic [ADDR_W-1:0] r_fill_addr;
   logic [ADDR_W-1:0] r_fill_left;
   logic [DATA_W-1:0] r_fill_value;
   logic              r_busy;
   logic              r_done;
   logic              r_b_ready;

   // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state      <= ST_IDLE;
         r_fill_addr  <= '0;
         r_fill_left  <= '0;
         r_fill_value <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_b_ready    <= 1'b1;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_clr_start) begin
                  r_fill_addr  <= i_clr_base;
                  r_fill_left  <= i_clr_count;
                  r_fill_value <= i_clr_value;
                  if (i_clr_count == '0) begin
                     r_state <= ST_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state   <= ST_RUN;
                     r_busy    <= 1'b1;
                     r_b_ready <= 1'b0;
                  end
               end
            end
            ST_RUN: begin
               r_fill_addr <= (r_fill_addr >= LP_LAST) ? '0 : r_fill_addr + 1'b1;
               r_fill_left <= r_fill_left - 1'b1;
               if (r_fill_left == ADDR_W'(1)) begin
                  r_state   <= ST_DONE;
                  r_busy    <= 1'b0;
                  r_b_ready <= 1'b1;
                  r_done    <= 1'b1;
               end
            end
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign w_fill_wr   = (r_state == ST_RUN);
   assign w_fill_addr = r_fill_addr;
   assign w_fill_data = r_fill_value;
   assign w_b_ready   = r_b_ready;
   assign o_clr_busy  = r_busy;
   assign o_clr_done  = r_done;
`else
   logic w_unused_clr;

   assign w_unused_clr = ^{i_clr_start, i_clr_base, i_clr_count, i_clr_value};
   assign w_fill_wr    = 1'b0;
   assign w_fill_addr  = '0;
   assign w_fill_data  = '0;
   assign w_b_ready    = 1'b1;
   assign o_clr_busy   = 1'b0;
   assign o_clr_done   = 1'b0;
`endif

   assign o_b_ready = w_b_ready;

   logic              w_a_in, w_a_rd, w_a_wr;
   logic              w_b_acc, w_b_in, w_b_rd_in, w_b_rd, w_b_wr, w_same_wr;
   logic [ADDR_W-1:0] w_b_addr;
   logic [BE_W-1:0]   w_b_be, w_b_be_eff;
   logic [DATA_W-1:0] w_b_data;

   assign w_a_in    = ({1'b0, i_a_address} < LP_DEPTH);
   assign w_a_rd    = i_a_enable & ~i_a_write_enable;
   assign w_a_wr    = i_a_enable & i_a_write_enable & w_a_in;
   assign w_b_acc   = i_b_enable & w_b_ready;
   assign w_b_rd    = w_b_acc & ~i_b_write_enable;
   assign w_b_rd_in = ({1'b0, i_b_address} < LP_DEPTH);
   // The fill engine borrows port B's write path, so it is arbitrated exactly like a port B write.
   assign w_b_addr  = w_fill_wr ? w_fill_addr : i_b_address;
   assign w_b_be    = w_fill_wr ? {BE_W{1'b1}} : i_b_byte_enable;
   assign w_b_data  = w_fill_wr ? w_fill_data : i_b_wr_data;
   assign w_b_in    = ({1'b0, w_b_addr} < LP_DEPTH);
   assign w_b_wr    = (w_fill_wr | (w_b_acc & i_b_write_enable)) & w_b_in;
   assign w_same_wr = w_a_wr & w_b_wr & (i_a_address == w_b_addr);
   assign w_b_be_eff = w_same_wr ? (w_b_be & ~i_a_byte_enable) : w_b_be;

   // NOTE: the array has no reset; contents survive i_reset and it stays mappable to block RAM.
   always_ff @(posedge i_clk) begin
      for (int k = 0; k < BE_W; k++) begin
         if (w_a_wr && i_a_byte_enable[k])
            r_mem[i_a_address[LP_IDX_W-1:0]][k*8 +: 8] <= i_a_wr_data[k*8 +: 8];
         if (w_b_wr && w_b_be_eff[k])
            r_mem[w_b_addr[LP_IDX_W-1:0]][k*8 +: 8] <= w_b_data[k*8 +: 8];
      end
   end

   logic              r_a_vld1, r_b_vld1, r_collision;
   logic [DATA_W-1:0] r_a_dat1, r_b_dat1;

   // Reads sample the array at the same edge as any write, which yields read-first behaviour.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_a_vld1    <= 1'b0;
         r_b_vld1    <= 1'b0;
         r_a_dat1    <= '0;
         r_b_dat1    <= '0;
         r_collision <= 1'b0;
      end else begin
         r_a_vld1    <= w_a_rd;
         r_b_vld1    <= w_b_rd;
         r_collision <= w_same_wr & (|(w_b_be & i_a_byte_enable));
         if (w_a_rd) r_a_dat1 <= w_a_in ? r_mem[i_a_address[LP_IDX_W-1:0]] : '0;
         if (w_b_rd) r_b_dat1 <= w_b_rd_in ? r_mem[i_b_address[LP_IDX_W-1:0]] : '0;
      end
   end

   assign o_collision = r_collision;

   generate
      if (RD_LATENCY == 2) begin : g_lat2
         logic              r_a_vld2, r_b_vld2;
         logic [DATA_W-1:0] r_a_dat2, r_b_dat2;

         always_ff @(posedge i_clk or posedge i_reset) begin
            if (i_reset) begin
               r_a_vld2 <= 1'b0;
               r_b_vld2 <= 1'b0;
               r_a_dat2 <= '0;
               r_b_dat2 <= '0;
            end else begin
               r_a_vld2 <= r_a_vld1;
               r_b_vld2 <= r_b_vld1;
               if (r_a_vld1) r_a_dat2 <= r_a_dat1;
               if (r_b_vld1) r_b_dat2 <= r_b_dat1;
            end
         end

         assign o_a_rd_valid = r_a_vld2;
         assign o_a_rd_data  = r_a_dat2;
         assign o_b_rd_valid = r_b_vld2;
         assign o_b_rd_data  = r_b_dat2;
      end else begin : g_lat1
         assign o_a_rd_valid = r_a_vld1;
         assign o_a_rd_data  = r_a_dat1;
         assign o_b_rd_valid = r_b_vld1;
         assign o_b_rd_data  = r_b_dat1;
      end
   endgenerate

endmodule

// File: tb/tb_vram_dp_clr.sv
// tb_vram_dp_clr: drives a latency-1 and a latency-2 instance with identical stimulus and compares
// both against a byte-level memory model with delayed read expectations.
module tb_vram_dp_clr;
   localparam int DW = 16;
   localparam int AW = 18;
   localparam int DEPTH = 153600;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic          a_en = 0, a_we = 0, b_en = 0, b_we = 0, clr_start = 0;
   logic [AW-1:0] a_addr = '0, b_addr = '0, clr_base = '0, clr_count = '0;
   logic [1:0]    a_be = '0, b_be = '0;
   logic [DW-1:0] a_wd = '0, b_wd = '0, clr_value = '0;

   logic [DW-1:0] a1_rd, b1_rd, a2_rd, b2_rd;
   logic a1_v, b1_v, a2_v, b2_v, rdy1, rdy2, coll1, coll2, busy1, busy2, done1, done2;

   vram_dp_clr #(.RD_LATENCY(1)) dut1 (
      .i_clk(clk), .i_reset(rst),
      .i_a_enable(a_en), .i_a_address(a_addr), .i_a_write_enable(a_we), .i_a_byte_enable(a_be),
      .i_a_wr_data(a_wd), .o_a_rd_data(a1_rd), .o_a_rd_valid(a1_v),
      .i_b_enable(b_en), .i_b_address(b_addr), .i_b_write_enable(b_we), .i_b_byte_enable(b_be),
      .i_b_wr_data(b_wd), .o_b_rd_data(b1_rd), .o_b_rd_valid(b1_v), .o_b_ready(rdy1),
      .o_collision(coll1), .i_clr_start(clr_start), .i_clr_base(clr_base), .i_clr_count(clr_count),
      .i_clr_value(clr_value), .o_clr_busy(busy1), .o_clr_done(done1));

   vram_dp_clr #(.RD_LATENCY(2)) dut2 (
      .i_clk(clk), .i_reset(rst),
      .i_a_enable(a_en), .i_a_address(a_addr), .i_a_write_enable(a_we), .i_a_byte_enable(a_be),
      .i_a_wr_data(a_wd), .o_a_rd_data(a2_rd), .o_a_rd_valid(a2_v),
      .i_b_enable(b_en), .i_b_address(b_addr), .i_b_write_enable(b_we), .i_b_byte_enable(b_be),
      .i_b_wr_data(b_wd), .o_b_rd_data(b2_rd), .o_b_rd_valid(b2_v), .o_b_ready(rdy2),
      .o_collision(coll2), .i_clr_start(clr_start), .i_clr_base(clr_base), .i_clr_count(clr_count),
      .i_clr_value(clr_value), .o_clr_busy(busy2), .o_clr_done(done2));

   int n_cmp = 0;
   int n_bad = 0;

   // Memory model: word value plus which bytes have ever been written.
   logic [15:0] model [int];
   logic [1:0]  known [int];

   // Read expectations per port (0 = A, 1 = B): request, latency-1 output, latency-2 output.
   bit          pv_v [2], e1_v [2], e2_v [2];
   bit          pv_k [2], e1_k [2], e2_k [2];
   logic [15:0] pv_d [2], e1_d [2], e2_d [2];

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic void mdl_write(int addr, logic [15:0] d, logic [1:0] be);
      logic [15:0] cur;
      logic [1:0]  kn;
      if (addr >= DEPTH) return;
      cur = model.exists(addr) ? model[addr] : 16'h0;
      kn  = known.exists(addr) ? known[addr] : 2'b00;
      if (be[0]) cur[7:0]  = d[7:0];
      if (be[1]) cur[15:8] = d[15:8];
      model[addr] = cur;
      known[addr] = kn | be;
   endfunction

   task automatic mdl_read(int addr, output logic [15:0] d, output bit k);
      if (addr >= DEPTH) begin
         d = 16'h0; k = 1;
      end else if (known.exists(addr) && known[addr] == 2'b11) begin
         d = model[addr]; k = 1;
      end else begin
         d = 16'h0; k = 0;
      end
   endtask

   task automatic clear_expect();
      for (int p = 0; p < 2; p++) begin
         pv_v[p] = 0; e1_v[p] = 0; e2_v[p] = 0;
         pv_k[p] = 1; e1_k[p] = 1; e2_k[p] = 1;
         pv_d[p] = 0; e1_d[p] = 0; e2_d[p] = 0;
      end
   endtask

   task automatic cmp_port(string tag, logic v, logic [15:0] d, bit ev, logic [15:0] ed, bit ek);
      check({tag, "_valid"}, {31'd0, v}, {31'd0, ev});
      if (ek) check({tag, "_data"}, {16'd0, d}, {16'd0, ed});
   endtask

   // One clock: apply current inputs to the model, advance one edge, compare every output.
   task automatic cycle();
      bit          rv [2];
      bit          rk [2];
      logic [15:0] rd [2];
      bit          exp_coll;
      rv[0] = a_en && !a_we;
      rv[1] = b_en && !b_we;
      mdl_read(int'(a_addr), rd[0], rk[0]);
      mdl_read(int'(b_addr), rd[1], rk[1]);
      exp_coll = a_en && a_we && b_en && b_we && (a_addr == b_addr) && (int'(a_addr) < DEPTH)
                 && ((a_be & b_be) != 2'b00);
      // Port A applied last so its bytes win on a shared address.
      if (b_en && b_we) mdl_write(int'(b_addr), b_wd, b_be);
      if (a_en && a_we) mdl_write(int'(a_addr), a_wd, a_be);
      @(posedge clk); #1;
      for (int p = 0; p < 2; p++) begin
         e2_v[p] = pv_v[p];
         if (pv_v[p]) begin e2_d[p] = pv_d[p]; e2_k[p] = pv_k[p]; end
         e1_v[p] = rv[p];
         if (rv[p]) begin e1_d[p] = rd[p]; e1_k[p] = rk[p]; end
         pv_v[p] = rv[p]; pv_d[p] = rd[p]; pv_k[p] = rk[p];
      end
      cmp_port("a_l1", a1_v, a1_rd, e1_v[0], e1_d[0], e1_k[0]);
      cmp_port("b_l1", b1_v, b1_rd, e1_v[1], e1_d[1], e1_k[1]);
      cmp_port("a_l2", a2_v, a2_rd, e2_v[0], e2_d[0], e2_k[0]);
      cmp_port("b_l2", b2_v, b2_rd, e2_v[1], e2_d[1], e2_k[1]);
      check("collision_l1", {31'd0, coll1}, {31'd0, exp_coll});
      check("collision_l2", {31'd0, coll2}, {31'd0, exp_coll});
   endtask

   task automatic idle();
      a_en = 0; b_en = 0; clr_start = 0;
   endtask

   task automatic set_a(logic we, int addr, logic [15:0] d, logic [1:0] be);
      a_en = 1; a_we = we; a_addr = AW'(addr); a_wd = d; a_be = be;
   endtask

   task automatic set_b(logic we, int addr, logic [15:0] d, logic [1:0] be);
      b_en = 1; b_we = we; b_addr = AW'(addr); b_wd = d; b_be = be;
   endtask

   task automatic do_reset();
      idle();
      rst = 1; #1;
      check("rst_a1_v", {31'd0, a1_v}, 0);   check("rst_a1_d", {16'd0, a1_rd}, 0);
      check("rst_b1_v", {31'd0, b1_v}, 0);   check("rst_b1_d", {16'd0, b1_rd}, 0);
      check("rst_a2_d", {16'd0, a2_rd}, 0);  check("rst_b2_d", {16'd0, b2_rd}, 0);
      check("rst_v2", {30'd0, a2_v, b2_v}, 0);
      check("rst_ready", {30'd0, rdy1, rdy2}, 32'h3);
      check("rst_coll", {30'd0, coll1, coll2}, 0);
      check("rst_busy", {30'd0, busy1, busy2}, 0);
      check("rst_done", {30'd0, done1, done2}, 0);
      clear_expect();
      @(posedge clk); #1;
      rst = 0;
   endtask

   task automatic fill_watch(int n_obs, int restart_at, output int n_busy, output int n_nrdy,
                             output int n_done, output int done_at);
      n_busy = 0; n_nrdy = 0; n_done = 0; done_at = -1;
      for (int i = 0; i < n_obs; i++) begin
         if (i > 0) cycle();
         if (busy1) n_busy++;
         if (!rdy1) n_nrdy++;
         if (done1) begin n_done++; done_at = i; end
         check("busy_l2_vs_l1_count", {31'd0, busy2}, {31'd0, busy1});
         clr_start = (i == restart_at);
         if (i == restart_at) begin clr_base = AW'(2000); clr_count = AW'(3); clr_value = 16'hDEAD; end
      end
      clr_start = 0;
   endtask

   initial begin
      int nb, nr, nd, da;
      clear_expect();
      #1;
      do_reset();

      // Byte-enable merge: 0x1234 then low byte 0xCD -> 0x12CD.
      set_a(1, 5, 16'h1234, 2'b11); cycle();
      set_a(1, 5, 16'hABCD, 2'b01); cycle(); idle();
      set_b(0, 5, 0, 0); cycle(); idle();
      check("be_merge_l1", {16'd0, b1_rd}, 32'h12CD);
      cycle();
      check("be_merge_l2", {16'd0, b2_rd}, 32'h12CD);
      check("be_l1_valid_one_cycle", {31'd0, b1_v}, 0);
      cycle();

      // Preload value = address, then back-to-back reads on B.
      for (int i = 0; i < 16; i++) begin set_a(1, i, 16'(i), 2'b11); cycle(); end
      set_a(1, DEPTH - 1, 16'h5A5A, 2'b11); cycle(); idle();
      for (int i = 0; i < 8; i++) begin
         set_b(0, i, 0, 0); cycle();
         check("sweep_l1", {15'd0, b1_v, b1_rd}, {15'd0, 1'b1, 16'(i)});
         if (i > 0) check("sweep_l2", {15'd0, b2_v, b2_rd}, {15'd0, 1'b1, 16'(i - 1)});
         else check("sweep_l2_first", {31'd0, b2_v}, 0);
      end
      idle(); cycle();
      check("sweep_l2_last", {15'd0, b2_v, b2_rd}, {15'd0, 1'b1, 16'd7});
      cycle();

      // Same-address writes: overlapping masks collide, disjoint masks merge.
      set_a(1, 100, 16'h1111, 2'b11); set_b(1, 100, 16'h2222, 2'b11); cycle(); idle();
      check("coll_full", {30'd0, coll1, coll2}, 32'h3);
      cycle();
      check("coll_pulse_end", {30'd0, coll1, coll2}, 0);
      set_b(0, 100, 0, 0); cycle(); idle();
      check("coll_full_data", {16'd0, b1_rd}, 32'h1111);
      set_a(1, 100, 16'h1111, 2'b10); set_b(1, 100, 16'h2222, 2'b01); cycle(); idle();
      check("coll_disjoint", {30'd0, coll1, coll2}, 0);
      set_a(0, 100, 0, 0); cycle(); idle();
      check("coll_disjoint_data", {16'd0, a1_rd}, 32'h1122);
      // A reads while B writes the same address: old data returned.
      set_a(0, 100, 0, 0); set_b(1, 100, 16'h7777, 2'b11); cycle(); idle();
      check("read_first", {16'd0, a1_rd}, 32'h1122);

      // Out-of-range: write ignored, read returns 0 with valid.
      set_a(1, DEPTH, 16'hBEEF, 2'b11); cycle(); idle();
      set_b(0, DEPTH, 0, 0); cycle(); idle();
      check("oor_read", {15'd0, b1_v, b1_rd}, {15'd0, 1'b1, 16'h0});
      cycle();

      // Randomised traffic on a small window plus range edges.
      for (int i = 0; i < 400; i++) begin
         int sel;
         a_en = 1'($urandom_range(0, 1)); a_we = 1'($urandom_range(0, 1));
         b_en = 1'($urandom_range(0, 1)); b_we = 1'($urandom_range(0, 1));
         a_be = 2'($urandom_range(0, 3)); b_be = 2'($urandom_range(0, 3));
         a_wd = 16'($urandom); b_wd = 16'($urandom);
         sel = int'($urandom_range(0, 19));
         a_addr = (sel == 0) ? AW'(DEPTH) : (sel == 1) ? AW'(DEPTH - 1) : AW'($urandom_range(0, 15));
         b_addr = ($urandom_range(0, 3) == 0) ? a_addr : AW'($urandom_range(0, 15));
         cycle();
      end
      idle(); cycle(); cycle();

`ifdef VRAM_CLR_EN
      // Fill with wrap, plus a B read accepted in the start cycle.
      clr_start = 1; clr_base = AW'(153598); clr_count = AW'(4); clr_value = 16'h07E0;
      set_b(0, 5, 0, 0); cycle(); idle();
      fill_watch(12, -1, nb, nr, nd, da);
      check("wrap_busy_cycles", nb, 4);
      check("wrap_notready_cycles", nr, 4);
      check("wrap_done_pulses", nd, 1);
      check("wrap_done_at", da, 4);
      for (int i = 0; i < 4; i++) mdl_write((153598 + i) % DEPTH, 16'h07E0, 2'b11);
      for (int i = 0; i < 4; i++) begin
         set_b(0, (153598 + i) % DEPTH, 0, 0); cycle(); idle();
         check("wrap_data", {16'd0, b1_rd}, 32'h07E0);
      end
      cycle(); cycle();

      // Zero count: done next cycle, busy never high.
      clr_start = 1; clr_base = AW'(50); clr_count = '0; cycle(); idle();
      check("zero_done", {30'd0, done1, busy1}, 32'h2);
      cycle();
      check("zero_after", {30'd0, done1, busy1}, 0);
      cycle();

      // Second start during RUN is ignored.
      set_a(1, 2000, 16'h2000, 2'b11); cycle(); idle();
      clr_start = 1; clr_base = AW'(1000); clr_count = AW'(10); clr_value = 16'hF00F; cycle(); idle();
      fill_watch(18, 2, nb, nr, nd, da);
      check("ign_busy_cycles", nb, 10);
      check("ign_done_pulses", nd, 1);
      for (int i = 0; i < 10; i++) mdl_write(1000 + i, 16'hF00F, 2'b11);
      set_b(0, 1009, 0, 0); cycle(); idle();
      check("ign_last_word", {16'd0, b1_rd}, 32'hF00F);
      set_b(0, 2000, 0, 0); cycle(); idle();
      check("ign_untouched", {16'd0, b1_rd}, 32'h2000);
      cycle();

      // Reset after three words of an eight-word fill.
      for (int i = 0; i < 8; i++) begin set_a(1, 200 + i, 16'hAA00 + 16'(i), 2'b11); cycle(); end
      idle();
      clr_start = 1; clr_base = AW'(200); clr_count = AW'(8); clr_value = 16'h5555; cycle(); idle();
      cycle(); cycle(); cycle();
      do_reset();
      for (int i = 0; i < 3; i++) mdl_write(200 + i, 16'h5555, 2'b11);
      nd = 0;
      for (int i = 0; i < 12; i++) begin cycle(); if (done1 || done2) nd++; end
      check("abort_no_done", nd, 0);
      for (int i = 0; i < 8; i++) begin
         set_b(0, 200 + i, 0, 0); cycle(); idle();
         check("abort_data", {16'd0, b1_rd}, (i < 3) ? 32'h5555 : 32'hAA00 + 32'(i));
      end
      cycle(); cycle();
`else
      // Without the fill engine the start pulse does nothing.
      set_a(1, 300, 16'h0300, 2'b11); cycle(); idle();
      clr_start = 1; clr_base = AW'(300); clr_count = AW'(4); clr_value = 16'h1234; cycle(); idle();
      for (int i = 0; i < 6; i++) begin
         check("noclr_outputs", {29'd0, busy1, done1, rdy1}, 32'h1);
         cycle();
      end
      set_b(0, 300, 0, 0); cycle(); idle();
      check("noclr_untouched", {16'd0, b1_rd}, 32'h0300);
      cycle(); cycle();
      do_reset();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
